// File: rtl/mem_pkg.sv
// Shared types and elaboration helpers for the memory responder and its channels.
package mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_READ_BUSY  = 3'd1,
        ST_WRITE_BUSY = 3'd2,
        ST_RESPOND    = 3'd3,
        ST_RELEASE    = 3'd4
    } state_e;

    localparam int CNT_BITS    = 32'sd4;
    localparam int MAX_LATENCY = (32'sd1 <<< CNT_BITS) - 32'sd1;

    // Latency must fit the down-counter and be at least one cycle.
    function automatic bit latency_ok(input int lat);
        return (lat >= 32'sd1) && (lat <= MAX_LATENCY);
    endfunction

endpackage

// File: rtl/mem_responder_channel.sv
// One request channel: accepts a read or write, waits the programmed latency,
// issues the storage access strobes and a one-cycle ready pulse.
module mem_responder_channel
    import mem_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rd_valid_i,
    input  logic [ADDR_BITS-1:0] rd_addr_i,
    input  logic                 wr_valid_i,
    input  logic [ADDR_BITS-1:0] wr_addr_i,
    input  logic [DATA_BITS-1:0] wr_data_i,
    output logic                 rd_ready_o,
    output logic                 wr_ready_o,
    output logic                 rd_sample_o,
    output logic [ADDR_BITS-1:0] rd_sample_addr_o,
    output logic                 commit_o,
    output logic [ADDR_BITS-1:0] commit_addr_o,
    output logic [DATA_BITS-1:0] commit_data_o
);

    localparam logic [CNT_BITS-1:0] RD_LOAD = CNT_BITS'(READ_LATENCY - 32'sd1);
    localparam logic [CNT_BITS-1:0] WR_LOAD = CNT_BITS'(WRITE_LATENCY - 32'sd1);
    localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(32'sd1);
    localparam bit RD_IMMEDIATE = (READ_LATENCY == 32'sd1);
    localparam bit WR_IMMEDIATE = (WRITE_LATENCY == 32'sd1);

    state_e                state_q;
    logic [CNT_BITS-1:0]   cnt_q;
    logic [ADDR_BITS-1:0]  addr_q;
    logic [DATA_BITS-1:0]  data_q;
    logic                  served_rd_q;
    logic                  rd_ready_q;
    logic                  wr_ready_q;

    logic                  rd_fire;
    logic                  wr_fire;
    logic [ADDR_BITS-1:0]  fire_addr;
    logic [DATA_BITS-1:0]  fire_data;

    // Decode the edge on which the access happens; latency 1 bypasses the latch.
    always_comb begin
        rd_fire   = 1'b0;
        wr_fire   = 1'b0;
        fire_addr = addr_q;
        fire_data = data_q;
        case (state_q)
            ST_IDLE: begin
                if (rd_valid_i) begin
                    rd_fire   = RD_IMMEDIATE;
                    fire_addr = rd_addr_i;
                end else if (wr_valid_i) begin
                    wr_fire   = WR_IMMEDIATE;
                    fire_addr = wr_addr_i;
                    fire_data = wr_data_i;
                end else begin
                    fire_addr = addr_q;
                end
            end
            ST_READ_BUSY: begin
                rd_fire = (cnt_q == CNT_ONE);
            end
            ST_WRITE_BUSY: begin
                wr_fire = (cnt_q == CNT_ONE);
            end
            default: begin
                rd_fire = 1'b0;
            end
        endcase
    end

    // Channel FSM with counter, latched request and registered ready pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_BITS{1'b0}};
            addr_q      <= {ADDR_BITS{1'b0}};
            data_q      <= {DATA_BITS{1'b0}};
            served_rd_q <= 1'b0;
            rd_ready_q  <= 1'b0;
            wr_ready_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rd_valid_i) begin
                        addr_q      <= rd_addr_i;
                        served_rd_q <= 1'b1;
                        if (rd_fire) begin
                            cnt_q      <= {CNT_BITS{1'b0}};
                            rd_ready_q <= 1'b1;
                            state_q    <= ST_RESPOND;
                        end else begin
                            cnt_q   <= RD_LOAD;
                            state_q <= ST_READ_BUSY;
                        end
                    end else if (wr_valid_i) begin
                        addr_q      <= wr_addr_i;
                        data_q      <= wr_data_i;
                        served_rd_q <= 1'b0;
                        if (wr_fire) begin
                            cnt_q      <= {CNT_BITS{1'b0}};
                            wr_ready_q <= 1'b1;
                            state_q    <= ST_RESPOND;
                        end else begin
                            cnt_q   <= WR_LOAD;
                            state_q <= ST_WRITE_BUSY;
                        end
                    end
                end
                ST_READ_BUSY: begin
                    cnt_q <= cnt_q - CNT_ONE;
                    if (rd_fire) begin
                        rd_ready_q <= 1'b1;
                        state_q    <= ST_RESPOND;
                    end
                end
                ST_WRITE_BUSY: begin
                    cnt_q <= cnt_q - CNT_ONE;
                    if (wr_fire) begin
                        wr_ready_q <= 1'b1;
                        state_q    <= ST_RESPOND;
                    end
                end
                ST_RESPOND: begin
                    rd_ready_q <= 1'b0;
                    wr_ready_q <= 1'b0;
                    state_q    <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    // A still-high valid belongs to the request already served.
                    if (served_rd_q ? !rd_valid_i : !wr_valid_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    rd_ready_q <= 1'b0;
                    wr_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign rd_ready_o       = rd_ready_q;
    assign wr_ready_o       = wr_ready_q;
    assign rd_sample_o      = rd_fire & ~reset;
    assign rd_sample_addr_o = fire_addr;
    assign commit_o         = wr_fire & ~reset;
    assign commit_addr_o    = fire_addr;
    assign commit_data_o    = fire_data;

endmodule

// File: rtl/mem_responder.sv
// Multi-channel latency-programmable memory responder over one shared storage
// array, with a backdoor preload port.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CHANNELS  = 1,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_read_valid    [NUM_CHANNELS-1:0],
    input  logic [ADDR_BITS-1:0] mem_read_address  [NUM_CHANNELS-1:0],
    output logic                 mem_read_ready    [NUM_CHANNELS-1:0],
    output logic [DATA_BITS-1:0] mem_read_data     [NUM_CHANNELS-1:0],
    input  logic                 mem_write_valid   [NUM_CHANNELS-1:0],
    input  logic [ADDR_BITS-1:0] mem_write_address [NUM_CHANNELS-1:0],
    input  logic [DATA_BITS-1:0] mem_write_data    [NUM_CHANNELS-1:0],
    output logic                 mem_write_ready   [NUM_CHANNELS-1:0],
    input  logic                 load_valid,
    input  logic [ADDR_BITS-1:0] load_address,
    input  logic [DATA_BITS-1:0] load_data
);

    localparam int DEPTH = 32'sd1 <<< ADDR_BITS;

    if (!latency_ok(READ_LATENCY) || !latency_ok(WRITE_LATENCY)) begin : g_bad_latency
        $fatal(1, "mem_responder: READ_LATENCY and WRITE_LATENCY must be 1..15");
    end

    logic [DATA_BITS-1:0] mem_q [0:DEPTH-1];
    logic [DATA_BITS-1:0] rdata_q [NUM_CHANNELS-1:0];

    logic                 rd_sample      [NUM_CHANNELS-1:0];
    logic [ADDR_BITS-1:0] rd_sample_addr [NUM_CHANNELS-1:0];
    logic                 commit         [NUM_CHANNELS-1:0];
    logic [ADDR_BITS-1:0] commit_addr    [NUM_CHANNELS-1:0];
    logic [DATA_BITS-1:0] commit_data    [NUM_CHANNELS-1:0];

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        mem_responder_channel #(
            .ADDR_BITS     (ADDR_BITS),
            .DATA_BITS     (DATA_BITS),
            .READ_LATENCY  (READ_LATENCY),
            .WRITE_LATENCY (WRITE_LATENCY)
        ) u_ch (
            .clk              (clk),
            .reset            (reset),
            .rd_valid_i       (mem_read_valid[c]),
            .rd_addr_i        (mem_read_address[c]),
            .wr_valid_i       (mem_write_valid[c]),
            .wr_addr_i        (mem_write_address[c]),
            .wr_data_i        (mem_write_data[c]),
            .rd_ready_o       (mem_read_ready[c]),
            .wr_ready_o       (mem_write_ready[c]),
            .rd_sample_o      (rd_sample[c]),
            .rd_sample_addr_o (rd_sample_addr[c]),
            .commit_o         (commit[c]),
            .commit_addr_o    (commit_addr[c]),
            .commit_data_o    (commit_data[c])
        );

        assign mem_read_data[c] = rdata_q[c];
    end

    // Storage writes: later assignments win, so load < channel 0 < ... < top channel.
    always_ff @(posedge clk) begin
        if (load_valid) begin
            mem_q[load_address] <= load_data;
        end
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (commit[c]) begin
                mem_q[commit_addr[c]] <= commit_data[c];
            end
        end
    end

    // Read data capture sees pre-edge contents and holds until the next read.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (reset) begin
                rdata_q[c] <= {DATA_BITS{1'b0}};
            end else if (rd_sample[c]) begin
                rdata_q[c] <= mem_q[rd_sample_addr[c]];
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with two channels and latency 2.
module tb_mem_responder;

    localparam int AB = 8;
    localparam int DB = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          rv  [1:0];
    logic [AB-1:0] ra  [1:0];
    logic          rr  [1:0];
    logic [DB-1:0] rd  [1:0];
    logic          wv  [1:0];
    logic [AB-1:0] wa  [1:0];
    logic [DB-1:0] wd  [1:0];
    logic          wr  [1:0];
    logic          lv;
    logic [AB-1:0] la;
    logic [DB-1:0] ld;

    int checks = 0;
    int errors = 0;

    mem_responder #(
        .ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(2),
        .READ_LATENCY(2), .WRITE_LATENCY(2)
    ) dut (
        .clk(clk), .reset(reset),
        .mem_read_valid(rv), .mem_read_address(ra),
        .mem_read_ready(rr), .mem_read_data(rd),
        .mem_write_valid(wv), .mem_write_address(wa), .mem_write_data(wd),
        .mem_write_ready(wr),
        .load_valid(lv), .load_address(la), .load_data(ld)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        lv = 1'b0; la = 8'h00; ld = 16'h0000;
        for (int c = 0; c < 2; c++) begin
            rv[c] = 1'b0; ra[c] = 8'h00;
            wv[c] = 1'b0; wa[c] = 8'h00; wd[c] = 16'h0000;
        end
        @(negedge clk);
        tick(); tick();
        check("rst_rready0", {31'd0, rr[0]}, 32'd0);
        check("rst_wready1", {31'd0, wr[1]}, 32'd0);
        check("rst_rdata0", {16'd0, rd[0]}, 32'd0);
        reset = 1'b0;

        // Preloads
        lv = 1'b1; la = 8'h10; ld = 16'h1234; tick();
        la = 8'h40; ld = 16'hCAFE; tick();
        la = 8'h70; ld = 16'h0F0F; tick();
        lv = 1'b0;

        // Read 0x10: ready exactly one cycle, two edges after accept
        rv[0] = 1'b1; ra[0] = 8'h10;
        tick();
        check("rd_early", {31'd0, rr[0]}, 32'd0);
        tick();
        check("rd_ready", {31'd0, rr[0]}, 32'd1);
        check("rd_data", {16'd0, rd[0]}, 32'h1234);
        rv[0] = 1'b0;
        tick();
        check("rd_pulse_end", {31'd0, rr[0]}, 32'd0);
        check("rd_data_hold", {16'd0, rd[0]}, 32'h1234);
        tick();

        // Write 0xBEEF to 0x20 then read it back
        wv[0] = 1'b1; wa[0] = 8'h20; wd[0] = 16'hBEEF;
        tick();
        check("wr_early", {31'd0, wr[0]}, 32'd0);
        tick();
        check("wr_ready", {31'd0, wr[0]}, 32'd1);
        wv[0] = 1'b0;
        tick();
        check("wr_pulse_end", {31'd0, wr[0]}, 32'd0);
        tick();
        rv[0] = 1'b1; ra[0] = 8'h20;
        tick(); tick();
        check("rdback_ready", {31'd0, rr[0]}, 32'd1);
        check("rdback_data", {16'd0, rd[0]}, 32'hBEEF);
        rv[0] = 1'b0;
        tick(); tick();

        // Read and write together: read first, write only after read valid drops
        rv[0] = 1'b1; ra[0] = 8'h10;
        wv[0] = 1'b1; wa[0] = 8'h50; wd[0] = 16'h5555;
        tick(); tick();
        check("both_rready", {31'd0, rr[0]}, 32'd1);
        check("both_wready", {31'd0, wr[0]}, 32'd0);
        check("both_rdata", {16'd0, rd[0]}, 32'h1234);
        rv[0] = 1'b0;
        tick();
        check("both_w_a", {31'd0, wr[0]}, 32'd0);
        tick();
        check("both_w_b", {31'd0, wr[0]}, 32'd0);
        tick();
        check("both_w_c", {31'd0, wr[0]}, 32'd0);
        tick();
        check("both_w_done", {31'd0, wr[0]}, 32'd1);
        wv[0] = 1'b0;
        tick(); tick();
        rv[0] = 1'b1; ra[0] = 8'h50;
        tick(); tick();
        check("both_w_data", {16'd0, rd[0]}, 32'h5555);
        rv[0] = 1'b0;
        tick(); tick();

        // Two channels commit to 0x30 on the same edge: channel 1 wins
        wv[0] = 1'b1; wa[0] = 8'h30; wd[0] = 16'h1111;
        wv[1] = 1'b1; wa[1] = 8'h30; wd[1] = 16'h2222;
        tick(); tick();
        check("dual_wready0", {31'd0, wr[0]}, 32'd1);
        check("dual_wready1", {31'd0, wr[1]}, 32'd1);
        wv[0] = 1'b0; wv[1] = 1'b0;
        tick(); tick();

        // ch0 reads 0x30 while ch1 writes it on the same edge: old value seen
        rv[0] = 1'b1; ra[0] = 8'h30;
        wv[1] = 1'b1; wa[1] = 8'h30; wd[1] = 16'h3333;
        tick(); tick();
        check("rbw_data", {16'd0, rd[0]}, 32'h2222);
        check("rbw_wready", {31'd0, wr[1]}, 32'd1);
        rv[0] = 1'b0; wv[1] = 1'b0;
        tick(); tick();
        rv[0] = 1'b1; ra[0] = 8'h30;
        tick(); tick();
        check("rbw_new", {16'd0, rd[0]}, 32'h3333);
        rv[0] = 1'b0;
        tick(); tick();

        // Channel commit beats load at the same address
        wv[1] = 1'b1; wa[1] = 8'h60; wd[1] = 16'hAAAA;
        tick();
        lv = 1'b1; la = 8'h60; ld = 16'h7777;
        tick();
        lv = 1'b0; wv[1] = 1'b0;
        tick(); tick();
        rv[1] = 1'b1; ra[1] = 8'h60;
        tick(); tick();
        check("ld_vs_commit", {16'd0, rd[1]}, 32'hAAAA);
        rv[1] = 1'b0;
        tick(); tick();

        // Reset during READ_BUSY and WRITE_BUSY
        rv[0] = 1'b1; ra[0] = 8'h40;
        wv[1] = 1'b1; wa[1] = 8'h70; wd[1] = 16'h9999;
        tick();
        reset = 1'b1;
        tick();
        check("mid_rst_rready", {31'd0, rr[0]}, 32'd0);
        check("mid_rst_wready", {31'd0, wr[1]}, 32'd0);
        check("mid_rst_rdata0", {16'd0, rd[0]}, 32'd0);
        check("mid_rst_rdata1", {16'd0, rd[1]}, 32'd0);
        reset = 1'b0; rv[0] = 1'b0; wv[1] = 1'b0;
        tick();
        check("post_rst_rready", {31'd0, rr[0]}, 32'd0);
        check("post_rst_wready", {31'd0, wr[1]}, 32'd0);
        tick();
        rv[0] = 1'b1; ra[0] = 8'h40;
        rv[1] = 1'b1; ra[1] = 8'h70;
        tick(); tick();
        check("rst_keep_preload", {16'd0, rd[0]}, 32'hCAFE);
        check("rst_lost_write", {16'd0, rd[1]}, 32'h0F0F);
        rv[0] = 1'b0; rv[1] = 1'b0;
        tick(); tick();

        // Valid held after ready: no re-accept until it drops and rises again
        rv[0] = 1'b1; ra[0] = 8'h10;
        tick(); tick();
        check("hold_first", {31'd0, rr[0]}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("hold_stale", {31'd0, rr[0]}, 32'd0);
        end
        rv[0] = 1'b0;
        tick();
        check("hold_low", {31'd0, rr[0]}, 32'd0);
        rv[0] = 1'b1; ra[0] = 8'h20;
        tick(); tick();
        check("hold_second", {31'd0, rr[0]}, 32'd1);
        check("hold_second_data", {16'd0, rd[0]}, 32'hBEEF);
        rv[0] = 1'b0;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Latency-programmable memory responder that answers the memory side of the valid/ready request protocol issued by the memory controllers. It serves NUM_CHANNELS independent channels, each with its own read and write request port, from one shared word-addressed storage array. It is the device end of the controller's memory interface and is used both as the simulation memory model and as the on-chip memory wrapper.

## Interface
Parameters:
- ADDR_BITS, 8, address width; storage depth is 2^ADDR_BITS words
- DATA_BITS, 16, word width
- NUM_CHANNELS, 1, number of independent request channels
- READ_LATENCY, 2, cycles from read request accept to read ready; legal values 1 to 15
- WRITE_LATENCY, 2, cycles from write request accept to write ready; legal values 1 to 15

Ports (channel-indexed ports are unpacked arrays [NUM_CHANNELS-1:0]):
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- mem_read_valid  in  NUM_CHANNELS  read request, held until ready observed
- mem_read_address  in  ADDR_BITS x NUM_CHANNELS  read address, stable while valid
- mem_read_ready  out  NUM_CHANNELS  one-cycle read completion pulse
- mem_read_data  out  DATA_BITS x NUM_CHANNELS  read data, valid while ready is high
- mem_write_valid  in  NUM_CHANNELS  write request, held until ready observed
- mem_write_address  in  ADDR_BITS x NUM_CHANNELS  write address
- mem_write_data  in  DATA_BITS x NUM_CHANNELS  write data
- mem_write_ready  out  NUM_CHANNELS  one-cycle write completion pulse
- load_valid  in  1  backdoor preload strobe
- load_address  in  ADDR_BITS  backdoor address
- load_data  in  DATA_BITS  backdoor data

## Operation
- Per-channel FSM: IDLE, READ_BUSY, WRITE_BUSY, RESPOND, RELEASE.
- IDLE: if read valid, latch address, load counter with READ_LATENCY-1, go READ_BUSY; else if write valid, latch address and data, load WRITE_LATENCY-1, go WRITE_BUSY. Read wins when both are valid.
- BUSY: decrement the counter. At 0, or directly from IDLE when the latency is 1:
  - for a read, register storage[addr] into read data and set read ready;
  - for a write, commit data to storage and set write ready.
  - Then go RESPOND.
- RESPOND: ready is high for exactly this cycle. Clear ready, go RELEASE.
- RELEASE: wait until the served valid (read or write, whichever was accepted) is low, then go IDLE. A valid still high here is stale and is never re-accepted.
- Read data holds its last value after ready falls.
- Storage arbitration, same cycle:
  - a read observes contents before that edge's writes;
  - multiple channel commits to one address: highest channel index wins;
  - a channel commit beats load_valid at the same address.
- load_valid writes storage[load_address] on any cycle, independent of channel state.
- Storage contents are not cleared by reset.

## Timing
- Request sampled in IDLE at edge k: ready is high during cycle k+LATENCY.
- With the controller dropping valid on the edge that samples ready, a channel's minimum request spacing is LATENCY+2 cycles.
- Reset values: all mem_read_ready = 0, mem_write_ready = 0, mem_read_data = 0, all FSMs IDLE, counters 0.
- Reset mid-operation: pending requests are dropped with no ready and no storage write. An uncommitted write is lost; a committed write persists.
- Counter is 4 bits. Latency outside 1 to 15 is a fatal elaboration error.
- Addresses use all ADDR_BITS with no wrap logic; every address is in range.

## Structure
- Package mem_pkg holds:
  - the FSM state enum (3-bit: IDLE, READ_BUSY, WRITE_BUSY, RESPOND, RELEASE);
  - the latency-counter width constant;
  - the latency-range check function.
- Sub-module mem_responder_channel holds one channel's FSM, counter and latched request. It outputs commit strobe, address and data, plus a read-sample strobe.
- The top holds the storage array, generate-instantiates the channels, and resolves write priority.

## Test plan
- Preload address 0x10 = 0x1234 via load; channel 0 reads 0x10 with READ_LATENCY=2 -> ready high exactly cycle k+2 for one cycle, data 0x1234.
- Channel 0 writes 0xBEEF to 0x20, then reads 0x20 -> write ready at k+2; read returns 0xBEEF.
- Read and write valid together on an idle channel -> read served first; write accepted only after RELEASE sees read valid low.
- Two channels write 0x1111 (ch0) and 0x2222 (ch1) to 0x30 completing the same cycle -> storage[0x30] = 0x2222.
- Reset asserted in READ_BUSY -> no ready pulse, ready and data 0, FSM IDLE; preloaded contents intact.
- Valid held high after ready pulse -> no second ready until valid falls and is raised again.
